iter_shift_unit: RTL and testbench
==================================

Name: iter_shift_unit

Overview:
Multi-cycle successor to the 8-bit combinational shifter: parametrised width, iterative shifting of up to STEP bits per cycle, valid/ready handshakes on both sides, and carry/zero status. Sits in the multi-cycle datapath beside the ALU. The control FSM launches a shift, the block runs for several cycles, and the control FSM collects the result. Mode encoding matches the existing shifter, so decode logic is reused unchanged.

Parameters:
WIDTH, 8, data width in bits; power of two, >= 4
SHAMT_W, 5, shift-amount width; must be >= log2(WIDTH)+1
STEP, 1, maximum bits shifted per cycle; 1 <= STEP <= WIDTH

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  request valid
in_ready  out  1  block can accept a request
in_data  in  WIDTH  operand
shift_amount  in  SHAMT_W  requested shift distance, unsigned
shift_type  in  3  000 rotl, 001 rotr, 010 asr, 011 lsl, 100 lsr, others pass-through
out_valid  out  1  result valid
out_ready  in  1  consumer accepts the result
out_data  out  WIDTH  result
out_carry  out  1  last bit shifted out
out_zero  out  1  out_data == 0

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, in_ready=1, out_valid=0, out_data=0, out_carry=0, out_zero=0, internal counter=0.
- FSM states are IDLE, SHIFT and DONE. in_ready=1 only in IDLE. out_valid=1 only in DONE.
- IDLE: when in_valid && in_ready, capture in_data, shift_type and the effective count, clear carry, then go to SHIFT.
- Effective count:
  - Rotates: shift_amount mod WIDTH.
  - lsl, lsr and asr: min(shift_amount, WIDTH).
  - Pass-through: 0.
- SHIFT, when remaining count > 0: shift the working register by k = min(STEP, remaining) in the captured mode, then subtract k from the count.
  - lsl and lsr: zero fill.
  - asr: fill with the captured MSB.
  - Rotates: the bits leaving one end wrap to the other end.
  - carry = the last bit to leave the register in this step (for rotates, the last bit that wrapped).
- SHIFT, when remaining count == 0: go to DONE. out_data holds the working register and out_zero is registered from it.
- Latency: out_valid rises 1 + ceil(count/STEP) + 1 cycles after the accept edge. A zero count gives out_valid 2 cycles after accept with out_data = in_data and carry=0.
- DONE: out_data, out_carry and out_zero stay stable while out_valid=1. On out_valid && out_ready, go to IDLE and set in_ready=1 on the next cycle. There is no same-cycle accept of a new request in DONE.
- in_data, shift_amount and shift_type are ignored outside the accept cycle; they may change freely during SHIFT and DONE.
- Boundary cases:
  - lsl or lsr by >= WIDTH: result 0. carry = bit shifted out at count WIDTH (lsl: original bit 0; lsr: original bit WIDTH-1).
  - asr by >= WIDTH: result is all copies of the sign bit; carry = sign bit.
  - Rotate by a multiple of WIDTH: count 0, result = operand, carry 0.
- Reset asserted during SHIFT or DONE: abort immediately to the reset values; the in-flight result is discarded.

Optional Feature:
Macro SHIFT_FLAGS_EN.
- Defined: out_carry and out_zero behave as specified above.
- Undefined: the carry/zero registers and logic are not built; out_carry and out_zero are tied to 0. Data, handshake and latency are unchanged.

Test Plan:
- WIDTH=8, STEP=1, rotl 0x81 by 1 -> out_data 0x03, out_carry 1, out_zero 0, out_valid 3 cycles after accept.
- asr 0x80 by 3 -> 0xF0, carry 0. asr 0x80 by 12 -> 0xFF, carry 1, out_valid 10 cycles after accept (count clamped to 8).
- lsl 0xFF by 9 -> 0x00, carry 1, out_zero 1. rotr 0x01 by 10 -> count 2 -> 0x40, carry 0. Mode 101 with 0x5A -> 0x5A, 2-cycle latency.
- STEP=4, lsr 0xF0 by 6 -> 2 shift cycles, 0x03, carry 1. Hold out_ready=0 for 5 cycles -> out_valid and outputs stable, in_ready=0, new in_valid ignored.
- Assert rst_n low mid-SHIFT -> all outputs 0 and in_ready=1 asynchronously. Next request after reset completes correctly.
- Back-to-back requests with out_ready tied 1 -> in_ready returns 1 the cycle after the handshake; no lost or duplicated results.

Source files
------------

// File: rtl/iter_shift_unit.sv
// iter_shift_unit: multi-cycle rotate/shift unit, up to STEP bits per cycle, valid/ready on both sides.
// Define SHIFT_FLAGS_EN to build the carry/zero status; otherwise out_carry/out_zero are tied to 0.
module iter_shift_unit #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned SHAMT_W = 5,
   parameter int unsigned STEP    = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [SHAMT_W-1:0] shift_amount,
   input  logic [2:0]         shift_type,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_carry,
   output logic               out_zero
);
   localparam int unsigned CNT_W = $clog2(WIDTH + 1);
   localparam int unsigned IDX_W = $clog2(WIDTH);

   localparam logic [2:0] MODE_ROTL = 3'b000;
   localparam logic [2:0] MODE_ROTR = 3'b001;
   localparam logic [2:0] MODE_ASR  = 3'b010;
   localparam logic [2:0] MODE_LSL  = 3'b011;
   localparam logic [2:0] MODE_LSR  = 3'b100;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] work;
   logic [WIDTH-1:0] next_work;
   logic [2:0]       mode;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] eff_cnt;
   logic [CNT_W-1:0] step_k;
   logic [CNT_W-1:0] back_k;

   // Effective count: rotates wrap modulo WIDTH, linear shifts saturate at WIDTH.
   always_comb begin
      eff_cnt = '0;
      case (shift_type)
         MODE_ROTL, MODE_ROTR: eff_cnt = CNT_W'(shift_amount[IDX_W-1:0]);
         MODE_ASR, MODE_LSL, MODE_LSR:
            eff_cnt = (shift_amount >= SHAMT_W'(WIDTH)) ? CNT_W'(WIDTH) : CNT_W'(shift_amount);
         default: eff_cnt = '0;
      endcase
   end

   // One iteration: shift by k = min(STEP, cnt); back_k = WIDTH-k is the wrap distance.
   always_comb begin
      step_k    = (cnt > CNT_W'(STEP)) ? CNT_W'(STEP) : cnt;
      back_k    = CNT_W'(WIDTH) - step_k;
      next_work = work;
      case (mode)
         MODE_ROTL: next_work = (work << step_k) | (work >> back_k);
         MODE_ROTR: next_work = (work >> step_k) | (work << back_k);
         MODE_ASR:  next_work = $unsigned($signed(work) >>> step_k);
         MODE_LSL:  next_work = work << step_k;
         MODE_LSR:  next_work = work >> step_k;
         default:   next_work = work;
      endcase
   end

`ifdef SHIFT_FLAGS_EN
   logic [IDX_W-1:0] hi_idx;
   logic [IDX_W-1:0] lo_idx;
   logic             step_carry;
   logic             carry;

   // Last bit leaving this iteration: left moves lose bit WIDTH-k, right moves lose bit k-1.
   always_comb begin
      hi_idx     = IDX_W'(back_k);
      lo_idx     = IDX_W'(step_k - CNT_W'(1));
      step_carry = 1'b0;
      case (mode)
         MODE_ROTL, MODE_LSL:           step_carry = work[hi_idx];
         MODE_ROTR, MODE_ASR, MODE_LSR: step_carry = work[lo_idx];
         default:                       step_carry = 1'b0;
      endcase
   end
`else
   assign out_carry = 1'b0;
   assign out_zero  = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_data  <= '0;
         work      <= '0;
         mode      <= '0;
         cnt       <= '0;
`ifdef SHIFT_FLAGS_EN
         carry     <= 1'b0;
         out_carry <= 1'b0;
         out_zero  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  work     <= in_data;
                  mode     <= shift_type;
                  cnt      <= eff_cnt;
                  in_ready <= 1'b0;
                  state    <= SHIFT;
`ifdef SHIFT_FLAGS_EN
                  carry    <= 1'b0;
`endif
               end
            end
            SHIFT: begin
               if (cnt != '0) begin
                  work  <= next_work;
                  cnt   <= cnt - step_k;
`ifdef SHIFT_FLAGS_EN
                  carry <= step_carry;
`endif
               end else begin
                  out_data  <= work;
                  state     <= DONE;
`ifdef SHIFT_FLAGS_EN
                  out_carry <= carry;
                  out_zero  <= (work == '0);
`endif
               end
            end
            DONE: begin
               // Result registers settle on entry; out_valid follows one cycle later.
               if (!out_valid) begin
                  out_valid <= 1'b1;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_iter_shift_unit.sv
// tb_iter_shift_unit: table-driven and scoreboard bench for iter_shift_unit at STEP=1 and STEP=4.
// Flag expectations follow SHIFT_FLAGS_EN (zero when the macro is undefined).
module tb_iter_shift_unit;
   localparam int unsigned W  = 8;
   localparam int unsigned SW = 5;

`ifdef SHIFT_FLAGS_EN
   localparam bit FLAGS = 1'b1;
`else
   localparam bit FLAGS = 1'b0;
`endif

   typedef struct {
      logic [W-1:0]  d;
      logic [SW-1:0] amt;
      logic [2:0]    typ;
      logic [W-1:0]  ed;
      logic          ec;
   } vec_t;

   typedef struct {
      logic [W-1:0] d;
      logic         c;
      logic         z;
      int           cnt;
      int           acc;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b1;
   logic [W-1:0]  in_data = '0;
   logic [SW-1:0] shift_amount = '0;
   logic [2:0]    shift_type = '0;
   logic [1:0]    in_ready_v;
   logic [1:0]    out_valid_v;
   logic [1:0]    out_carry_v;
   logic [1:0]    out_zero_v;
   logic [W-1:0]  out_data_v [2];

   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc = 0;
   exp_t sb[$];
   int   rd[2];
   logic [1:0] vprev = '0;
   logic [1:0] hsprev = '0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   iter_shift_unit #(.WIDTH(W), .SHAMT_W(SW), .STEP(1)) u_s1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[0]),
      .in_data(in_data), .shift_amount(shift_amount), .shift_type(shift_type),
      .out_valid(out_valid_v[0]), .out_ready(out_ready), .out_data(out_data_v[0]),
      .out_carry(out_carry_v[0]), .out_zero(out_zero_v[0]));

   iter_shift_unit #(.WIDTH(W), .SHAMT_W(SW), .STEP(4)) u_s4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[1]),
      .in_data(in_data), .shift_amount(shift_amount), .shift_type(shift_type),
      .out_valid(out_valid_v[1]), .out_ready(out_ready), .out_data(out_data_v[1]),
      .out_carry(out_carry_v[1]), .out_zero(out_zero_v[1]));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Bit-at-a-time reference: result, last bit out, effective count.
   function automatic void model(input logic [W-1:0] d, input logic [SW-1:0] a, input logic [2:0] t,
                                 output logic [W-1:0] r, output logic c, output int n);
      r = d;
      c = 1'b0;
      case (t)
         3'b000, 3'b001:         n = int'(a) % int'(W);
         3'b010, 3'b011, 3'b100: n = (int'(a) > int'(W)) ? int'(W) : int'(a);
         default:                n = 0;
      endcase
      for (int i = 0; i < n; i++) begin
         case (t)
            3'b000: begin c = r[W-1]; r = {r[W-2:0], r[W-1]}; end
            3'b001: begin c = r[0];   r = {r[0], r[W-1:1]}; end
            3'b010: begin c = r[0];   r = {r[W-1], r[W-1:1]}; end
            3'b011: begin c = r[W-1]; r = {r[W-2:0], 1'b0}; end
            default: begin c = r[0];  r = {1'b0, r[W-1:1]}; end
         endcase
      end
   endfunction

   function automatic int exp_lat(input int cnt, input int j);
      int s;
      s = (j == 0) ? 1 : 4;
      return (cnt == 0) ? 2 : (cnt + s - 1) / s + 2;
   endfunction

   // Output monitor: every valid cycle is checked against the head of that DUT's queue.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         vprev  = '0;
         hsprev = '0;
      end else begin
         for (int j = 0; j < 2; j++) begin
            if (hsprev[j]) chk($sformatf("in_ready_after_hs[%0d]", j), 32'(in_ready_v[j]), 32'd1);
            hsprev[j] = 1'b0;
            if (out_valid_v[j]) begin
               if (rd[j] >= sb.size()) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL spurious_out[%0d]: out_valid=1, required no pending result", j);
               end else begin
                  e = sb[rd[j]];
                  if (!vprev[j])
                     chk($sformatf("latency[%0d]", j), 32'(cyc - e.acc), 32'(exp_lat(e.cnt, j)));
                  chk($sformatf("out_data[%0d]", j), 32'(out_data_v[j]), 32'(e.d));
                  chk($sformatf("out_carry[%0d]", j), 32'(out_carry_v[j]), 32'(FLAGS & e.c));
                  chk($sformatf("out_zero[%0d]", j), 32'(out_zero_v[j]), 32'(FLAGS & e.z));
                  chk($sformatf("in_ready_busy[%0d]", j), 32'(in_ready_v[j]), 32'd0);
                  if (out_ready) begin
                     rd[j]++;
                     hsprev[j] = 1'b1;
                  end
               end
            end
            vprev[j] = out_valid_v[j];
         end
      end
   end

   task automatic set_ready(input logic v);
      @(posedge clk);
      #1 out_ready = v;
   endtask

   task automatic issue(input logic [W-1:0] d, input logic [SW-1:0] a, input logic [2:0] t,
                        input logic [W-1:0] ed, input logic ec, input bit use_tbl);
      exp_t e;
      logic [W-1:0] mr;
      logic mc;
      int n;
      int k;
      model(d, a, t, mr, mc, n);
      k = 0;
      @(negedge clk);
      while (in_ready_v != 2'b11 && k < 200) begin
         @(negedge clk);
         k++;
      end
      if (k >= 200) begin
         n_cmp++;
         n_err++;
         $display("FAIL accept_wait: in_ready=%b after 200 cycles, required 11", in_ready_v);
         return;
      end
      e.d   = use_tbl ? ed : mr;
      e.c   = use_tbl ? ec : mc;
      e.z   = (e.d == '0);
      e.cnt = n;
      in_valid     = 1'b1;
      in_data      = d;
      shift_amount = a;
      shift_type   = t;
      @(posedge clk);
      #1;
      e.acc = cyc;
      sb.push_back(e);
      in_valid     = 1'b0;
      in_data      = W'($urandom);
      shift_amount = SW'($urandom);
      shift_type   = 3'($urandom);
   endtask

   task automatic drain();
      int k;
      k = 0;
      while ((rd[0] != sb.size() || rd[1] != sb.size()) && k < 300) begin
         @(negedge clk);
         k++;
      end
      if (k >= 300) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain: consumed %0d/%0d of %0d results", rd[0], rd[1], sb.size());
      end
   endtask

   task automatic wait_both_valid();
      int k;
      k = 0;
      while (out_valid_v != 2'b11 && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (k >= 50) begin
         n_cmp++;
         n_err++;
         $display("FAIL wait_valid: out_valid=%b, required 11", out_valid_v);
      end
   endtask

   task automatic chk_reset_state(input string tag);
      for (int j = 0; j < 2; j++) begin
         chk($sformatf("%s_in_ready[%0d]", tag, j), 32'(in_ready_v[j]), 32'd1);
         chk($sformatf("%s_out_valid[%0d]", tag, j), 32'(out_valid_v[j]), 32'd0);
         chk($sformatf("%s_out_data[%0d]", tag, j), 32'(out_data_v[j]), 32'd0);
         chk($sformatf("%s_out_carry[%0d]", tag, j), 32'(out_carry_v[j]), 32'd0);
         chk($sformatf("%s_out_zero[%0d]", tag, j), 32'(out_zero_v[j]), 32'd0);
      end
   endtask

   initial begin
      vec_t tbl[16];
      tbl[0]  = '{8'h81, 5'd1,  3'b000, 8'h03, 1'b1};
      tbl[1]  = '{8'h80, 5'd3,  3'b010, 8'hF0, 1'b0};
      tbl[2]  = '{8'h80, 5'd12, 3'b010, 8'hFF, 1'b1};
      tbl[3]  = '{8'hFF, 5'd9,  3'b011, 8'h00, 1'b1};
      tbl[4]  = '{8'h01, 5'd10, 3'b001, 8'h40, 1'b0};
      tbl[5]  = '{8'h5A, 5'd7,  3'b101, 8'h5A, 1'b0};
      tbl[6]  = '{8'hF0, 5'd6,  3'b100, 8'h03, 1'b1};
      tbl[7]  = '{8'hA5, 5'd8,  3'b000, 8'hA5, 1'b0};
      tbl[8]  = '{8'h3C, 5'd16, 3'b001, 8'h3C, 1'b0};
      tbl[9]  = '{8'h81, 5'd8,  3'b100, 8'h00, 1'b1};
      tbl[10] = '{8'h01, 5'd8,  3'b011, 8'h00, 1'b1};
      tbl[11] = '{8'h96, 5'd0,  3'b011, 8'h96, 1'b0};
      tbl[12] = '{8'h7F, 5'd31, 3'b010, 8'h00, 1'b0};
      tbl[13] = '{8'h96, 5'd3,  3'b001, 8'hD2, 1'b1};
      tbl[14] = '{8'h00, 5'd5,  3'b111, 8'h00, 1'b0};
      tbl[15] = '{8'h0F, 5'd2,  3'b011, 8'h3C, 1'b0};
      rd[0] = 0;
      rd[1] = 0;

      repeat (2) @(negedge clk);
      chk_reset_state("reset");
      #2 rst_n = 1'b1;

      // Directed table, consumer always ready: back-to-back requests.
      for (int i = 0; i < 16; i++)
         issue(tbl[i].d, tbl[i].amt, tbl[i].typ, tbl[i].ed, tbl[i].ec, 1'b1);
      drain();

      for (int i = 0; i < 24; i++)
         issue(W'($urandom), SW'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), '0, 1'b0, 1'b0);
      drain();

      // Backpressure: results held while out_ready is low, new requests refused.
      set_ready(1'b0);
      issue(8'hF0, 5'd6, 3'b100, 8'h03, 1'b1, 1'b1);
      wait_both_valid();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid   = 1'b1;
         in_data    = W'($urandom);
         shift_type = 3'b011;
         chk($sformatf("hold_in_ready[%0d]", i), 32'(in_ready_v), 32'd0);
         chk($sformatf("hold_out_valid[%0d]", i), 32'(out_valid_v), 32'd3);
      end
      @(negedge clk);
      in_valid = 1'b0;
      set_ready(1'b1);
      drain();

      // Reset mid-flight: STEP=1 still shifting, STEP=4 holding a result.
      set_ready(1'b0);
      issue(8'h5A, 5'd7, 3'b000, 8'h2D, 1'b1, 1'b1);
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk_reset_state("abort");
      rd[0] = sb.size();
      rd[1] = sb.size();
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      set_ready(1'b1);
      issue(8'h81, 5'd1, 3'b000, 8'h03, 1'b1, 1'b1);
      issue(8'hFF, 5'd9, 3'b011, 8'h00, 1'b1, 1'b1);
      drain();

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, compared=%0d mismatched=%0d", n_cmp, n_err);
      $fatal(1);
   end

endmodule
